fifo_drain_arbiter: RTL and testbench

- Drains a bank of 16 output FIFO lanes through the 16:1 lane mux (4-bit select) into a single registered output stream.
- Scans the lane empty flags round-robin, drives the mux select and a one-hot read strobe, and captures the muxed word.
- Presents the captured word downstream with a valid/ready handshake.
- Sits between the FIFO bank plus lane mux and the downstream consumer (SRAM writer or PSUM accumulator).

---
 rtl/fifo_drain_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Purpose:
//   Drains a bank of 16 FIFO lanes through an external 16:1 lane mux into one
//   registered output stream. In ARB the block picks a non-empty lane, drives
//   the mux select, and enters READ. In READ it pulses that lane's read
//   strobe for one cycle and captures the muxed word into the output slot on
//   the same edge that pops the FIFO.
//
// Build option:
//   FIFO_DRAIN_FIXED_PRI_EN - when defined, ARB always grants the lowest-index
//   non-empty lane and rr_ptr stays at 0. When undefined, the search starts
//   at rr_ptr (one past the last lane read) and wraps 15->0.
//
// Ports:
//   clk        in   clock, rising-edge active
//   reset      in   asynchronous, active-high reset
//   en         in   drain enable; 0 blocks new grants (a READ in flight completes)
//   empty      in   [15:0] per-lane FIFO empty flags
//   mux_out    in   [bw-1:0] lane mux data for the current sel
//   out_ready  in   downstream accepts out_data this cycle
//   sel        out  [3:0] registered lane select to the mux
//   rd         out  [15:0] one-hot FIFO read strobe, non-zero only in READ
//   out_data   out  [bw-1:0] captured word (registered)
//   out_valid  out  out_data holds an unconsumed word
//   busy       out  high in READ or while out_valid=1
//   dbg_state  out  current FSM state (0 = ARB, 1 = READ)
//
// Output handshake (valid/ready):
//   A word transfers on every rising edge where out_valid=1 and out_ready=1.
//   out_data and out_valid are held unchanged while out_valid=1 and
//   out_ready=0. out_valid drops after a transfer unless a READ refills the
//   slot on that same edge. ARB grants only when the slot will be free at
//   the grant edge, so a READ never finds the slot occupied.
// -----------------------------------------------------------------------------
module fifo_drain_arbiter #(
    parameter int bw = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [15:0]   empty,
    input  logic [bw-1:0] mux_out,
    input  logic          out_ready,
    output logic [3:0]    sel,
    output logic [15:0]   rd,
    output logic [bw-1:0] out_data,
    output logic          out_valid,
    output logic          busy,
    output logic          dbg_state
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t        r_state;
    logic [3:0]    r_sel;
    logic [3:0]    r_rr_ptr;
    logic [bw-1:0] r_out_data;
    logic          r_out_valid;

    logic          w_any;
    logic [3:0]    w_grant;
    logic [3:0]    w_idx;
    logic          w_slot_free;
    logic          w_consumed;
    logic          w_grant_ok;

    // Search lanes rr_ptr, rr_ptr+1, ... with natural 4-bit wrap; the first
    // non-empty lane wins. In the fixed-priority build rr_ptr never leaves 0,
    // so the same search yields the lowest-index non-empty lane.
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_rr_ptr;
        w_idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            w_idx = r_rr_ptr + 4'(k);
            if (!w_any && !empty[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_consumed  = r_out_valid && out_ready;
    assign w_slot_free = !r_out_valid || out_ready;
    assign w_grant_ok  = en && w_any && w_slot_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_ARB;
            r_sel       <= 4'd0;
            r_rr_ptr    <= 4'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_consumed) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_grant_ok) begin
                        r_sel   <= w_grant;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // The FIFO pops on this edge; its head word is on mux_out now.
                    r_out_data  <= mux_out;
                    r_out_valid <= 1'b1;
`ifdef FIFO_DRAIN_FIXED_PRI_EN
                    r_rr_ptr    <= 4'd0;
`else
                    r_rr_ptr    <= r_sel + 4'd1;
`endif
                    r_state     <= ST_ARB;
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    // rd depends only on registered state, so an asynchronous reset removes
    // the strobe immediately.
    assign rd        = (r_state == ST_READ) ? (16'h0001 << r_sel) : 16'h0000;
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_READ) || r_out_valid;
    assign dbg_state = (r_state == ST_READ);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
module tb_fifo_drain_arbiter;
  localparam int BW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] empty = 16'hFFFF;
  logic [BW-1:0] mux_out = '0;
  logic [3:0] sel;
  logic [15:0] rd;
  logic [BW-1:0] out_data;
  logic out_valid;
  logic busy;
  logic dbg_state;

  always #5 clk = ~clk;

  fifo_drain_arbiter #(.bw(BW)) dut (
    .clk(clk), .reset(reset), .en(en), .empty(empty), .mux_out(mux_out),
    .out_ready(out_ready), .sel(sel), .rd(rd), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- lane FIFOs and scoreboard ----------------
  logic [BW-1:0] fifo_q[16][$];
  logic [BW-1:0] exp_q[$];
  int dut_grants[$];
  int dut_reads;
  int vectors = 0;
  int miscompares = 0;

  // Reference model: a pending read (lane number) and a one-word output slot.
  bit m_reading;
  int m_sel;
  int m_ptr;
  logic [BW-1:0] m_data;
  bit m_valid;

  logic [15:0] dut_rd_s;
  logic [BW-1:0] dut_data_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_grant();
    int base;
`ifdef FIFO_DRAIN_FIXED_PRI_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < 16; k++) begin
      if (fifo_q[(base + k) % 16].size() != 0) return (base + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_init();
    m_reading = 0;
    m_sel = 0;
    m_ptr = 0;
    m_data = '0;
    m_valid = 0;
    exp_q.delete();
    dut_rd_s = '0;
  endtask

  task automatic push(input int lane, input logic [BW-1:0] w);
    fifo_q[lane].push_back(w);
  endtask

  task automatic refill(input logic [15:0] lanes, input int depth);
    for (int i = 0; i < 16; i++)
      if (lanes[i] && fifo_q[i].size() < depth) fifo_q[i].push_back(BW'($urandom));
  endtask

  task automatic update_inputs();
    for (int i = 0; i < 16; i++) empty[i] = (fifo_q[i].size() == 0);
    if (fifo_q[sel].size() != 0) mux_out = fifo_q[sel][0];
    else mux_out = BW'($urandom);
  endtask

  // Advance the model by one rising edge using the inputs applied to the DUT.
  task automatic model_step();
    bit consumed;
    int g;
    consumed = m_valid && out_ready;
    if (consumed) begin
      if (exp_q.size() == 0) chk("scoreboard_underflow", 1, 0);
      else chk("consumed_word", dut_data_s, exp_q.pop_front());
    end
    if (m_reading) begin
      m_data = fifo_q[m_sel][0];
      m_valid = 1;
      exp_q.push_back(m_data);
`ifdef FIFO_DRAIN_FIXED_PRI_EN
      m_ptr = 0;
`else
      m_ptr = (m_sel + 1) % 16;
`endif
      m_reading = 0;
    end else begin
      g = find_grant();
      if (en && g >= 0 && (!m_valid || out_ready)) begin
        m_sel = g;
        m_reading = 1;
      end
      if (consumed) m_valid = 0;
    end
    // The real FIFOs pop on whatever the DUT strobed.
    for (int i = 0; i < 16; i++) begin
      if (dut_rd_s[i]) begin
        chk("rd_lane_nonempty", fifo_q[i].size() != 0, 1);
        if (fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] erd;
    erd = m_reading ? (16'h0001 << m_sel) : 16'h0000;
    chk("sel", sel, m_sel);
    chk("rd", rd, erd);
    chk("out_data", out_data, m_data);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, m_reading || m_valid);
    chk("dbg_state", dbg_state, m_reading);
    dut_rd_s = rd;
    dut_data_s = out_data;
    if (rd != 16'h0) begin
      dut_grants.push_back(int'(sel));
      dut_reads++;
    end
  endtask

  // One clock: apply inputs, model the edge, compare on the falling edge.
  task automatic tick();
    update_inputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input bit clear_fifos);
    reset = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    if (clear_fifos) for (int i = 0; i < 16; i++) fifo_q[i].delete();
    model_init();
    update_inputs();
    @(posedge clk);
    @(negedge clk);
    chk("reset_sel", sel, 0);
    chk("reset_rd", rd, 16'h0000);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    dut_grants.delete();
    dut_reads = 0;
  endtask

  task automatic chk_order(input string name, input int a, input int b, input int c, input int d);
    if (dut_grants.size() < 4) chk({name, "_count"}, dut_grants.size(), 4);
    else begin
      chk({name, "_0"}, dut_grants[0], a);
      chk({name, "_1"}, dut_grants[1], b);
      chk({name, "_2"}, dut_grants[2], c);
      chk({name, "_3"}, dut_grants[3], d);
    end
  endtask

  initial begin
    // ---- single lane, latency of two edges ----
    do_reset(1);
    push(3, 4'hA);
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("single_sel", sel, 3);
    chk("single_rd", rd, 16'h0008);
    tick();
    chk("single_data", out_data, 4'hA);
    chk("single_valid", out_valid, 1);
    chk("single_rd_done", rd, 16'h0000);
    for (int i = 0; i < 3; i++) tick();
    chk("single_reads", dut_reads, 1);

    // ---- round-robin across lanes 2, 5, 15 ----
    do_reset(1);
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      refill(16'h8024, 2);
      tick();
    end
`ifdef FIFO_DRAIN_FIXED_PRI_EN
    chk_order("rr_order", 2, 2, 2, 2);
`else
    chk_order("rr_order", 2, 5, 15, 2);
`endif

    // ---- backpressure ----
    do_reset(1);
    push(0, 4'h5);
    push(1, 4'h6);
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("bp_rd0", rd, 16'h0001);
    out_ready = 1'b0;
    tick();
    chk("bp_data0", out_data, 4'h5);
    chk("bp_valid0", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_rd", rd, 16'h0000);
      chk("bp_hold_data", out_data, 4'h5);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_sel1", sel, 1);
    chk("bp_rd1", rd, 16'h0002);
    tick();
    chk("bp_data1", out_data, 4'h6);
    chk("bp_valid1", out_valid, 1);
    tick();

    // ---- enable low, then drop enable during READ ----
    do_reset(1);
    for (int i = 0; i < 16; i++) push(i, BW'(i));
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en0_rd", rd, 16'h0000);
      chk("en0_busy", busy, 0);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("en_drop_reads", dut_reads, 1);

    // ---- reset in the middle of a READ ----
    do_reset(1);
    push(2, 4'h9);
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("mid_rd_before", rd, 16'h0004);
    #2 reset = 1'b1;
    #1;
    chk("mid_rd_abort", rd, 16'h0000);
    chk("mid_valid", out_valid, 0);
    chk("mid_sel", sel, 0);
    chk("mid_busy", busy, 0);
    model_init();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    push(1, 4'h3);
    tick();
    chk("post_reset_sel", sel, 1);
    chk("post_reset_rd", rd, 16'h0002);
    for (int i = 0; i < 6; i++) tick();

    // ---- lanes 0 and 9 persistently non-empty ----
    do_reset(1);
    en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      refill(16'h0201, 2);
      tick();
    end
`ifdef FIFO_DRAIN_FIXED_PRI_EN
    chk_order("alt_order", 0, 0, 0, 0);
`else
    chk_order("alt_order", 0, 9, 0, 9);
`endif

    // ---- randomized traffic ----
    do_reset(1);
    for (int c = 0; c < 800; c++) begin
      int n;
      n = $urandom_range(0, 2);
      for (int p = 0; p < n; p++) begin
        int lane;
        lane = $urandom_range(0, 15);
        if (fifo_q[lane].size() < 4) push(lane, BW'($urandom));
      end
      en = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
